// File: rtl/adc_tap_seek_ctrl.sv
// Channel-A frame-clock IDELAY eye search: sweeps all 32 taps against the training pattern,
// loads the centre of the longest passing window and confirms it by readback.
module adc_tap_seek_ctrl #(
   parameter logic [7:0]  TRAIN_PATTERN = 8'hA5,
   parameter int unsigned SETTLE_CYC    = 16,
   parameter int unsigned N_SAMPLES     = 256,
   parameter int unsigned MIN_EYE       = 4
) (
   input  logic       clk_div_a,
   input  logic       sys_rst_n,
   input  logic       gclk_sd_lockeda,
   input  logic       seek_start,
   input  logic [7:0] adc_frame,
   input  logic [4:0] a_CNTVALUEOUT,
   output logic [4:0] a_CNTVALUEIN,
   output logic       a_load,
   output logic       auto_seek_rsta,
   output logic       seek_busy,
   output logic       seek_done,
   output logic       seek_err,
   output logic [4:0] eye_start,
   output logic [5:0] eye_len
);

   localparam int unsigned     CntW       = 16;
   localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);
   localparam logic [CntW-1:0] SampleLast = CntW'(N_SAMPLES - 1);
   localparam logic [5:0]      MinEye     = 6'(MIN_EYE);

   typedef enum logic [3:0] {
      StIdle, StRstDly, StLoad, StSettle, StSample, StEval,
      StFinalLoad, StFinalSettle, StVerify, StDone, StErr
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [4:0]      tap_q, tap_d;
   logic [4:0]      cur_start_q, cur_start_d;
   logic [4:0]      best_start_q, best_start_d;
   logic [5:0]      cur_len_q, cur_len_d;
   logic [5:0]      best_len_q, best_len_d;
   logic            fail_q, fail_d;
   logic [4:0]      final_tap;
   logic            idle_like, start_acc;

   logic [4:0] cntvalue_d, eye_start_d;
   logic [5:0] eye_len_d;
   logic       load_d, rsta_d, busy_d, done_d, err_d;

   assign idle_like = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr);
   assign start_acc = idle_like && seek_start && gclk_sd_lockeda;
   assign cnt_d     = (state_d == state_q) ? cnt_q + CntW'(1) : '0;

   // Scoring datapath; depends on state_q only so the FSM can see the post-EVAL best window.
   always_comb begin
      tap_d        = tap_q;
      cur_start_d  = cur_start_q;
      cur_len_d    = cur_len_q;
      best_start_d = best_start_q;
      best_len_d   = best_len_q;
      fail_d       = fail_q;
      if (start_acc) begin
         tap_d        = '0;
         cur_start_d  = '0;
         cur_len_d    = '0;
         best_start_d = '0;
         best_len_d   = '0;
      end
      unique case (state_q)
         StLoad:   fail_d = 1'b0;
         StSample: if (adc_frame != TRAIN_PATTERN) fail_d = 1'b1;
         StEval: begin
            if (!fail_q) begin
               if (cur_len_q == 6'd0) cur_start_d = tap_q;
               cur_len_d = cur_len_q + 6'd1;
               // Strictly greater: the earliest of equal-length windows is kept.
               if (cur_len_d > best_len_q) begin
                  best_len_d   = cur_len_d;
                  best_start_d = cur_start_d;
               end
            end else begin
               cur_len_d = '0;
            end
            if (tap_q != 5'd31) tap_d = tap_q + 5'd1;
         end
         default: ;
      endcase
      final_tap = best_start_d + best_len_d[5:1];
   end

   always_ff @(posedge clk_div_a) begin
      if (!sys_rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         tap_q        <= '0;
         cur_start_q  <= '0;
         cur_len_q    <= '0;
         best_start_q <= '0;
         best_len_q   <= '0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         tap_q        <= tap_d;
         cur_start_q  <= cur_start_d;
         cur_len_q    <= cur_len_d;
         best_start_q <= best_start_d;
         best_len_q   <= best_len_d;
         fail_q       <= fail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!gclk_sd_lockeda && !idle_like) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle, StDone, StErr: if (start_acc) state_d = StRstDly;
            StRstDly:      state_d = StLoad;
            StLoad:        state_d = StSettle;
            StSettle:      if (cnt_q == SettleLast) state_d = StSample;
            StSample:      if (cnt_q == SampleLast) state_d = StEval;
            StEval: begin
               if (tap_q != 5'd31)          state_d = StLoad;
               else if (best_len_d >= MinEye) state_d = StFinalLoad;
               else                          state_d = StErr;
            end
            StFinalLoad:   state_d = StFinalSettle;
            StFinalSettle: if (cnt_q == SettleLast) state_d = StVerify;
            StVerify:      state_d = (a_CNTVALUEOUT == final_tap) ? StDone : StErr;
            default:       state_d = StIdle;
         endcase
      end
   end

   // Outputs are decoded from the next state and registered, so they align with state_q.
   always_comb begin
      load_d      = (state_d == StLoad) || (state_d == StFinalLoad);
      rsta_d      = (state_d == StRstDly);
      busy_d      = (state_d != StIdle) && (state_d != StDone) && (state_d != StErr);
      done_d      = (state_d == StDone);
      err_d       = (state_d == StErr);
      cntvalue_d  = a_CNTVALUEIN;
      eye_start_d = eye_start;
      eye_len_d   = eye_len;
      if (state_d == StLoad)           cntvalue_d = tap_d;
      else if (state_d == StFinalLoad) cntvalue_d = final_tap;
      if ((done_d || err_d) && (state_d != state_q)) begin
         eye_start_d = best_start_d;
         eye_len_d   = best_len_d;
      end
   end

   always_ff @(posedge clk_div_a) begin
      if (!sys_rst_n) begin
         a_CNTVALUEIN   <= '0;
         a_load         <= 1'b0;
         auto_seek_rsta <= 1'b0;
         seek_busy      <= 1'b0;
         seek_done      <= 1'b0;
         seek_err       <= 1'b0;
         eye_start      <= '0;
         eye_len        <= '0;
      end else begin
         a_CNTVALUEIN   <= cntvalue_d;
         a_load         <= load_d;
         auto_seek_rsta <= rsta_d;
         seek_busy      <= busy_d;
         seek_done      <= done_d;
         seek_err       <= err_d;
         eye_start      <= eye_start_d;
         eye_len        <= eye_len_d;
      end
   end

endmodule

// File: tb/tb_adc_tap_seek_ctrl.sv
// Scoreboard bench for adc_tap_seek_ctrl with a behavioural IDELAY/ADC model.
module tb_adc_tap_seek_ctrl;

   localparam int SETTLE  = 16;
   localparam int NS      = 256;
   localparam int PER_TAP = 2 + SETTLE + NS;
   localparam int FULL    = 1 + 32 * PER_TAP + 1 + SETTLE + 1;
   localparam int ERR31   = 1 + 32 * PER_TAP;

   logic       clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       lock = 1'b1;
   logic       seek_start = 1'b0;
   logic [7:0] adc_frame;
   logic [4:0] cntvalueout;
   logic [4:0] a_CNTVALUEIN;
   logic       a_load, auto_seek_rsta, seek_busy, seek_done, seek_err;
   logic [4:0] eye_start;
   logic [5:0] eye_len;

   always #5 clk = ~clk;

   adc_tap_seek_ctrl dut (
      .clk_div_a       (clk),
      .sys_rst_n       (sys_rst_n),
      .gclk_sd_lockeda (lock),
      .seek_start      (seek_start),
      .adc_frame       (adc_frame),
      .a_CNTVALUEOUT   (cntvalueout),
      .a_CNTVALUEIN    (a_CNTVALUEIN),
      .a_load          (a_load),
      .auto_seek_rsta  (auto_seek_rsta),
      .seek_busy       (seek_busy),
      .seek_done       (seek_done),
      .seek_err        (seek_err),
      .eye_start       (eye_start),
      .eye_len         (eye_len)
   );

   // Delay element + ADC model
   logic [4:0]  model_tap = '0;
   logic [31:0] pass_map = '1;
   logic [4:0]  rb_off = '0;
   logic        inject = 1'b0;
   int          since_load = 0;
   logic        bad;

   always @(posedge clk) begin
      if (auto_seek_rsta) model_tap <= '0;
      if (a_load) model_tap <= a_CNTVALUEIN;
      since_load <= a_load ? 1 : since_load + 1;
   end
   // Last sample cycle of tap 10
   assign bad         = inject && (model_tap == 5'd10) && (since_load == SETTLE + NS);
   assign adc_frame   = (pass_map[model_tap] && !bad) ? 8'hA5 : 8'h3C;
   assign cntvalueout = model_tap + rb_off;

   typedef struct {
      int done; int err; int es; int el; int last_load; int n_loads; int cycles;
   } exp_t;
   exp_t sb_q[$];

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT enters DONE or ERR
   int   cyc = 0, start_cyc = 0, n_loads = 0, last_load = 0, n_results = 0;
   logic pb = 1'b0, pd = 1'b0, pe = 1'b0;
   exp_t e;
   always @(negedge clk) begin
      cyc++;
      if (seek_busy && !pb) begin
         start_cyc = cyc;
         n_loads   = 0;
      end
      if (a_load) begin
         n_loads++;
         last_load = int'(a_CNTVALUEIN);
      end
      if ((seek_done && !pd) || (seek_err && !pe)) begin
         n_results++;
         if (sb_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("seek_done", int'(seek_done), e.done);
            check("seek_err", int'(seek_err), e.err);
            check("eye_start", int'(eye_start), e.es);
            check("eye_len", int'(eye_len), e.el);
            check("last_load_val", last_load, e.last_load);
            check("load_pulses", n_loads, e.n_loads);
            check("scan_cycles", cyc - start_cyc, e.cycles);
         end
      end
      pb = seek_busy;
      pd = seek_done;
      pe = seek_err;
   end

   task automatic run_scan(input logic [31:0] map, input logic inj, input logic [4:0] off,
                           input int done, input int err, input int es, input int el,
                           input int ll, input int nl, input int cycles);
      exp_t x;
      int   seen;
      int   t;
      pass_map = map;
      inject   = inj;
      rb_off   = off;
      x = '{done, err, es, el, ll, nl, cycles};
      sb_q.push_back(x);
      seen = n_results;
      @(negedge clk); seek_start = 1'b1;
      @(negedge clk); seek_start = 1'b0;
      t = 0;
      while (n_results == seen && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (n_results == seen) begin
         check("scan_timeout", 0, 1);
         sb_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cntvaluein"}, int'(a_CNTVALUEIN), 0);
      check({tag, "_load"}, int'(a_load), 0);
      check({tag, "_rsta"}, int'(auto_seek_rsta), 0);
      check({tag, "_busy"}, int'(seek_busy), 0);
      check({tag, "_done"}, int'(seek_done), 0);
      check({tag, "_err"}, int'(seek_err), 0);
      check({tag, "_eye_start"}, int'(eye_start), 0);
      check({tag, "_eye_len"}, int'(eye_len), 0);
   endtask

   initial begin
      int t;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      sys_rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // All taps pass: whole range, centre 16
      run_scan(32'hFFFF_FFFF, 1'b0, 5'd0, 1, 0, 0, 32, 16, 33, FULL);
      // Taps 5..14 pass
      run_scan(32'h0000_7FE0, 1'b0, 5'd0, 1, 0, 5, 10, 10, 33, FULL);
      // Equal windows 3..7 and 20..24: first wins
      run_scan(32'h01F0_00F8, 1'b0, 5'd0, 1, 0, 3, 5, 5, 33, FULL);
      // Window 9..11 shorter than MIN_EYE: no final load
      run_scan(32'h0000_0E00, 1'b0, 5'd0, 0, 1, 9, 3, 31, 32, ERR31);
      // Bad last sample on tap 10 splits 0..31 into 0..9 / 11..31; readback off by one
      run_scan(32'hFFFF_FFFF, 1'b1, 5'd1, 0, 1, 11, 21, 21, 33, FULL);

      // Lock loss during tap 12
      pass_map = '1;
      inject   = 1'b0;
      rb_off   = '0;
      @(negedge clk); seek_start = 1'b1;
      @(negedge clk); seek_start = 1'b0;
      t = 0;
      while (!(a_load && a_CNTVALUEIN == 5'd12) && t < 10000) begin
         @(negedge clk);
         t++;
      end
      check("tap12_load_seen", int'(a_load && a_CNTVALUEIN == 5'd12), 1);
      repeat (5) @(negedge clk);
      lock = 1'b0;
      @(negedge clk);
      check("lockloss_busy", int'(seek_busy), 0);
      check("lockloss_done", int'(seek_done), 0);
      check("lockloss_err", int'(seek_err), 0);
      check("lockloss_load", int'(a_load), 0);
      repeat (4) @(negedge clk);
      check("lockloss_no_restart", int'(seek_busy), 0);
      lock = 1'b1;
      @(negedge clk); seek_start = 1'b1;
      @(negedge clk); seek_start = 1'b0;
      check("restart_rsta", int'(auto_seek_rsta), 1);
      check("restart_busy", int'(seek_busy), 1);
      @(negedge clk);
      check("restart_load", int'(a_load), 1);
      check("restart_tap0", int'(a_CNTVALUEIN), 0);

      // Reset mid-SAMPLE of tap 0
      repeat (SETTLE + 10) @(negedge clk);
      sys_rst_n = 1'b0;
      @(negedge clk);
      check_all_zero("midreset");
      sys_rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("sb_empty", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_tap_seek_ctrl.md
# adc_tap_seek_ctrl

Sequences the ADC frame-clock IDELAY to find the centre of the data eye for channel A. The block sweeps all 32 delay taps and scores each tap against the ADC training pattern. It then loads the centre of the longest passing window and verifies the loaded value by readback. It runs in the `clk_div_a` domain (156.25 MHz), is gated by `gclk_sd_lockeda`, and drives the delay element's `CNTVALUEIN`/load and `auto_seek_rsta` controls.

## Interface
- `TRAIN_PATTERN`, 8'hA5: expected deserialized frame word during training.
- `SETTLE_CYC`, 16: cycles waited after each tap load before sampling (≥1).
- `N_SAMPLES`, 256: compare cycles per tap (≥1).
- `MIN_EYE`, 4: minimum passing-window length, in taps, for success (1..32).

Ports:
- `clk_div_a`  in  1  sole clock, 156.25 MHz.
- `sys_rst_n`  in  1  reset, synchronous, active-low.
- `gclk_sd_lockeda`  in  1  clock-stable qualifier; the block is idle while low.
- `seek_start`  in  1  one-cycle start/restart request.
- `adc_frame`  in  8  deserialized frame word, one per cycle.
- `a_CNTVALUEOUT`  in  5  tap readback from the delay element.
- `a_CNTVALUEIN`  out  5  tap value to the delay element.
- `a_load`  out  1  one-cycle load strobe for `a_CNTVALUEIN`.
- `auto_seek_rsta`  out  1  delay-element reset, high for 1 cycle at scan start.
- `seek_busy`  out  1  high while scanning.
- `seek_done`  out  1  sticky success flag.
- `seek_err`  out  1  sticky failure flag.
- `eye_start`  out  5  first tap of the chosen window.
- `eye_len`  out  6  length of the chosen window, 0..32.

## Operation
- States: IDLE, RST_DLY, LOAD, SETTLE, SAMPLE, EVAL, FINAL_LOAD, FINAL_SETTLE, VERIFY, DONE, ERR.
- IDLE → RST_DLY: on `seek_start`=1 while `gclk_sd_lockeda`=1. The same transition applies from DONE or ERR.
- Scan start: `seek_done` and `seek_err` clear, and `tap`, `cur_len` and `best_len` are cleared to 0.
- RST_DLY (1 cycle): `auto_seek_rsta`=1, then go to LOAD.
- LOAD (1 cycle): `a_CNTVALUEIN`=`tap`, `a_load`=1, then go to SETTLE. `a_CNTVALUEIN` holds its value until the next load.
- SETTLE: lasts `SETTLE_CYC` cycles, then go to SAMPLE.
- SAMPLE: lasts `N_SAMPLES` cycles. A tap fails if any `adc_frame` ≠ `TRAIN_PATTERN` in this window.
- EVAL (1 cycle), pass case: if `cur_len`=0, set `cur_start`=`tap`. Then `cur_len`+1. If the new `cur_len` > `best_len` (strictly greater), copy it into `best_start`/`best_len`. On ties, the first window wins.
- EVAL, fail case: `cur_len`=0.
- EVAL, next step: if `tap`<31, increment `tap` and go to LOAD. If `tap`=31, check `best_len`: if `best_len` ≥ `MIN_EYE`, go to FINAL_LOAD; otherwise go to ERR.
- Final tap = `best_start` + (`best_len`>>1), computed at 6 bits. It cannot exceed 31 because the window lies within 0..31.
- FINAL_LOAD (1 cycle): load the final tap. Then FINAL_SETTLE for `SETTLE_CYC` cycles.
- VERIFY (1 cycle): if `a_CNTVALUEOUT` = final tap, go to DONE; otherwise go to ERR.
- DONE: `seek_done`=1. ERR: `seek_err`=1. Both hold until the next scan start or reset.
- `eye_start`/`eye_len` update on entry to DONE or ERR, with `best_*` (0/0 if no tap passed).
- Lock loss: `gclk_sd_lockeda`=0 in any state other than IDLE/DONE/ERR forces IDLE next cycle. In that case `seek_busy`=0, `a_load`=0, and `seek_done`/`seek_err` stay 0. There is no automatic restart.
- `seek_start` is ignored while busy.

## Timing
- Reset (`sys_rst_n`=0 at a clock edge): state=IDLE. All outputs are 0: `a_CNTVALUEIN`=0, `a_load`=0, `auto_seek_rsta`=0, busy/done/err=0, `eye_start`=0, `eye_len`=0.
- Reset mid-scan behaves the same; reset has priority over lock loss and over `seek_start`.
- `seek_busy`=1 from RST_DLY through VERIFY inclusive.
- Per-tap time = 2 + `SETTLE_CYC` + `N_SAMPLES` cycles, which is 274 at the defaults.
- Full scan time = 1 + 32·(per-tap) + 1 + `SETTLE_CYC` + 1 cycles from start acceptance to DONE/ERR entry.
- `a_load` is high for exactly one cycle per tap.
- `adc_frame` is sampled on the cycles the FSM is in SAMPLE only.
- All outputs are registered.

## Test plan
- Pattern always correct → `eye_start`=0, `eye_len`=32, final load 16, `seek_done`=1 at the computed cycle count. There are 33 `a_load` pulses.
- Pattern correct only while `a_CNTVALUEIN` ∈ 5..14 → `eye_start`=5, `eye_len`=10, final tap 10, `seek_done`=1.
- Passing windows at 3..7 and 20..24 → `eye_start`=3, `eye_len`=5, final tap 5. This checks that the first window wins ties.
- Window 9..11 only (len 3 < `MIN_EYE`=4) → ERR with `seek_err`=1, `eye_start`=9, `eye_len`=3, and no final load. Also inject one bad word at sample 255 of tap 10 only, and confirm that tap fails.
- Readback forced to final tap+1 → `seek_err`=1 and `seek_done`=0.
- Drop lock during tap 12 → IDLE next cycle with busy/done/err=0. Then `seek_start` restarts, issuing `auto_seek_rsta` and a fresh scan from tap 0.
- Assert `sys_rst_n`=0 mid-SAMPLE → all outputs 0 at the next edge.
